// File: rtl/pll_axi_pkg.sv
// Shared state encoding and AXI response codes for the PLL reconfiguration AXI4-Lite initiator.
package pll_axi_pkg;

    localparam int unsigned PLL_AXI_ADDR_W = 11;

    localparam logic [1:0] AXI_OKAY   = 2'b00;
    localparam logic [1:0] AXI_SLVERR = 2'b10;
    localparam logic [1:0] AXI_DECERR = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_RESP,
        DONE
    } pll_axi_state_t;

endpackage

// File: rtl/pll_axi_master.sv
// Single-outstanding AXI4-Lite initiator: one register command in, one response pulse out.
// Optional per-transaction abort guard enabled by defining PLL_AXI_TIMEOUT_EN.
module pll_axi_master
    import pll_axi_pkg::*;
#(
    parameter int unsigned ADDR_W         = PLL_AXI_ADDR_W,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic              clk_100m,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic [3:0]        cmd_wstrb,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [1:0]        rsp_resp,
    output logic              rsp_timeout,
    output logic              busy,
    output logic [ADDR_W-1:0] m_axi_awaddr,
    output logic              m_axi_awvalid,
    input  logic              m_axi_awready,
    output logic [DATA_W-1:0] m_axi_wdata,
    output logic [3:0]        m_axi_wstrb,
    output logic              m_axi_wvalid,
    input  logic              m_axi_wready,
    input  logic [1:0]        m_axi_bresp,
    input  logic              m_axi_bvalid,
    output logic              m_axi_bready,
    output logic [ADDR_W-1:0] m_axi_araddr,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    input  logic [DATA_W-1:0] m_axi_rdata,
    input  logic [1:0]        m_axi_rresp,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready
);

    if (DATA_W != 32 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
        $error("pll_axi_master: DATA_W must be 32 and TIMEOUT_CYCLES at least 2");
    end

    pll_axi_state_t r_state;
    logic           r_aw_done;
    logic           r_w_done;

    logic w_aw_hs;
    logic w_w_hs;
    logic w_b_hs;
    logic w_ar_hs;
    logic w_r_hs;
    logic w_wr_done;
    logic w_step_done;
    logic w_expire;

    assign w_aw_hs   = m_axi_awvalid & m_axi_awready;
    assign w_w_hs    = m_axi_wvalid & m_axi_wready;
    assign w_b_hs    = m_axi_bvalid & m_axi_bready;
    assign w_ar_hs   = m_axi_arvalid & m_axi_arready;
    assign w_r_hs    = m_axi_rvalid & m_axi_rready;
    assign w_wr_done = (r_aw_done | w_aw_hs) & (r_w_done | w_w_hs);

    // A handshake that completes the current state beats a coincident expiry.
    always_comb begin
        w_step_done = 1'b0;
        case (r_state)
            WR_REQ:  w_step_done = w_wr_done;
            WR_RESP: w_step_done = w_b_hs;
            RD_REQ:  w_step_done = w_ar_hs;
            RD_RESP: w_step_done = w_r_hs;
            default: w_step_done = 1'b0;
        endcase
    end

`ifdef PLL_AXI_TIMEOUT_EN
    localparam int unsigned TO_W = ($clog2(TIMEOUT_CYCLES + 1) > 10) ?
                                   $clog2(TIMEOUT_CYCLES + 1) : 10;

    logic [TO_W-1:0] r_to_cnt;

    // Held at zero while idle, so it starts clean at every command accept.
    always_ff @(posedge clk_100m) begin
        if (reset || r_state == IDLE) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
        end
    end

    assign w_expire = (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
    assign w_expire = 1'b0;
`endif

    always_ff @(posedge clk_100m) begin
        if (reset) begin
            r_state       <= IDLE;
            r_aw_done     <= 1'b0;
            r_w_done      <= 1'b0;
            cmd_ready     <= 1'b1;
            busy          <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_rdata     <= '0;
            rsp_resp      <= AXI_OKAY;
            rsp_timeout   <= 1'b0;
            m_axi_awaddr  <= '0;
            m_axi_awvalid <= 1'b0;
            m_axi_wdata   <= '0;
            m_axi_wstrb   <= '0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
            m_axi_araddr  <= '0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cmd_valid) begin
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                        if (cmd_write) begin
                            m_axi_awaddr  <= cmd_addr;
                            m_axi_wdata   <= cmd_wdata;
                            m_axi_wstrb   <= cmd_wstrb;
                            m_axi_awvalid <= 1'b1;
                            m_axi_wvalid  <= 1'b1;
                            r_state       <= WR_REQ;
                        end else begin
                            m_axi_araddr  <= cmd_addr;
                            m_axi_arvalid <= 1'b1;
                            r_state       <= RD_REQ;
                        end
                    end
                end
                WR_REQ: begin
                    // AW and W retire independently; move on once both have.
                    if (w_aw_hs) begin
                        m_axi_awvalid <= 1'b0;
                        r_aw_done     <= 1'b1;
                    end
                    if (w_w_hs) begin
                        m_axi_wvalid <= 1'b0;
                        r_w_done     <= 1'b1;
                    end
                    if (w_wr_done) begin
                        m_axi_bready <= 1'b1;
                        r_state      <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (w_b_hs) begin
                        m_axi_bready <= 1'b0;
                        rsp_valid    <= 1'b1;
                        rsp_rdata    <= '0;
                        rsp_resp     <= m_axi_bresp;
                        rsp_timeout  <= 1'b0;
                        r_state      <= DONE;
                    end
                end
                RD_REQ: begin
                    if (w_ar_hs) begin
                        m_axi_arvalid <= 1'b0;
                        m_axi_rready  <= 1'b1;
                        r_state       <= RD_RESP;
                    end
                end
                RD_RESP: begin
                    if (w_r_hs) begin
                        m_axi_rready <= 1'b0;
                        rsp_valid    <= 1'b1;
                        rsp_rdata    <= m_axi_rdata;
                        rsp_resp     <= m_axi_rresp;
                        rsp_timeout  <= 1'b0;
                        r_state      <= DONE;
                    end
                end
                DONE: begin
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                    r_state   <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase

            // Abort overrides whatever the state logic above scheduled.
            if (w_expire && !w_step_done && r_state != IDLE && r_state != DONE) begin
                m_axi_awvalid <= 1'b0;
                m_axi_wvalid  <= 1'b0;
                m_axi_bready  <= 1'b0;
                m_axi_arvalid <= 1'b0;
                m_axi_rready  <= 1'b0;
                rsp_valid     <= 1'b1;
                rsp_rdata     <= '0;
                rsp_resp      <= AXI_SLVERR;
                rsp_timeout   <= 1'b1;
                r_state       <= DONE;
            end
        end
    end

endmodule

// File: tb/tb_pll_axi_master.sv
// Bench for pll_axi_master: a cycle-stepped AXI4-Lite slave with per-channel wait states and a
// latency/response model derived from the handshake rules. Timeout checks follow PLL_AXI_TIMEOUT_EN.
module tb_pll_axi_master;
    import pll_axi_pkg::*;

    localparam int unsigned ADDR_W = 11;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned TO_CYC = 16;

    logic              clk_100m = 1'b0;
    logic              reset;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic [3:0]        cmd_wstrb;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic [1:0]        rsp_resp;
    logic              rsp_timeout;
    logic              busy;
    logic [ADDR_W-1:0] m_axi_awaddr;
    logic              m_axi_awvalid;
    logic              m_axi_awready;
    logic [DATA_W-1:0] m_axi_wdata;
    logic [3:0]        m_axi_wstrb;
    logic              m_axi_wvalid;
    logic              m_axi_wready;
    logic [1:0]        m_axi_bresp;
    logic              m_axi_bvalid;
    logic              m_axi_bready;
    logic [ADDR_W-1:0] m_axi_araddr;
    logic              m_axi_arvalid;
    logic              m_axi_arready;
    logic [DATA_W-1:0] m_axi_rdata;
    logic [1:0]        m_axi_rresp;
    logic              m_axi_rvalid;
    logic              m_axi_rready;

    int n_vec = 0;
    int n_err = 0;

    // Observations gathered by run_txn, judged by the test tasks.
    int              obs_rsp_k;
    int              obs_ready_k;
    int              obs_pulses;
    int              obs_aw_hi;
    int              obs_w_hi;
    int              obs_ar_hi;
    int              obs_aw_hs;
    int              obs_w_hs;
    int              obs_ar_hs;
    int              obs_b_hs;
    int              obs_r_hs;
    int              obs_bus_bad;
    int              obs_stat_bad;
    int              obs_to_seen;
    logic [DATA_W-1:0] obs_rdata;
    logic [1:0]      obs_resp;
    logic            obs_timeout;

    pll_axi_master #(
        .ADDR_W         (ADDR_W),
        .DATA_W         (DATA_W),
        .TIMEOUT_CYCLES (TO_CYC)
    ) u_dut (
        .clk_100m      (clk_100m),
        .reset         (reset),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_write     (cmd_write),
        .cmd_addr      (cmd_addr),
        .cmd_wdata     (cmd_wdata),
        .cmd_wstrb     (cmd_wstrb),
        .rsp_valid     (rsp_valid),
        .rsp_rdata     (rsp_rdata),
        .rsp_resp      (rsp_resp),
        .rsp_timeout   (rsp_timeout),
        .busy          (busy),
        .m_axi_awaddr  (m_axi_awaddr),
        .m_axi_awvalid (m_axi_awvalid),
        .m_axi_awready (m_axi_awready),
        .m_axi_wdata   (m_axi_wdata),
        .m_axi_wstrb   (m_axi_wstrb),
        .m_axi_wvalid  (m_axi_wvalid),
        .m_axi_wready  (m_axi_wready),
        .m_axi_bresp   (m_axi_bresp),
        .m_axi_bvalid  (m_axi_bvalid),
        .m_axi_bready  (m_axi_bready),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_arready (m_axi_arready),
        .m_axi_rdata   (m_axi_rdata),
        .m_axi_rresp   (m_axi_rresp),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rready  (m_axi_rready)
    );

    always #5 clk_100m = ~clk_100m;

    task automatic slave_idle();
        m_axi_awready = 1'b0;
        m_axi_wready  = 1'b0;
        m_axi_bvalid  = 1'b0;
        m_axi_bresp   = 2'b00;
        m_axi_arready = 1'b0;
        m_axi_rvalid  = 1'b0;
        m_axi_rdata   = '0;
        m_axi_rresp   = 2'b00;
    endtask

    // Issues one command at the current negedge, then plays the slave for max_k cycles.
    // Cycle k=1 is the first cycle after the accepting edge.
    task automatic run_txn(input logic wr, input logic [ADDR_W-1:0] addr,
                           input logic [DATA_W-1:0] wdata, input logic [3:0] wstrb,
                           input int aw_dly, input int w_dly, input int b_dly,
                           input int ar_dly, input int r_dly, input logic [1:0] s_resp,
                           input logic [DATA_W-1:0] s_rdata, input int max_k);
        int aw_k;
        int w_k;
        int ar_k;
        bit b_done;
        bit r_done;
        aw_k = 0; w_k = 0; ar_k = 0; b_done = 0; r_done = 0;
        obs_rsp_k = -1; obs_ready_k = -1; obs_pulses = 0;
        obs_aw_hi = 0; obs_w_hi = 0; obs_ar_hi = 0;
        obs_aw_hs = 0; obs_w_hs = 0; obs_ar_hs = 0; obs_b_hs = 0; obs_r_hs = 0;
        obs_bus_bad = 0; obs_stat_bad = 0; obs_to_seen = 0;
        obs_rdata = '0; obs_resp = 2'b00; obs_timeout = 1'b0;
        if (cmd_ready !== 1'b1) obs_stat_bad++;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        cmd_wstrb = wstrb;
        @(posedge clk_100m);
        @(negedge clk_100m);
        cmd_valid = 1'b0;
        cmd_addr  = ADDR_W'($urandom);
        cmd_wdata = $urandom;
        cmd_wstrb = 4'($urandom);
        for (int k = 1; k <= max_k; k++) begin
            if (b_done && m_axi_bready) obs_bus_bad++;
            if (r_done && m_axi_rready) obs_bus_bad++;
            if (m_axi_awvalid) begin
                obs_aw_hi++;
                if (m_axi_awaddr !== addr) obs_bus_bad++;
            end
            if (m_axi_wvalid) begin
                obs_w_hi++;
                if (m_axi_wdata !== wdata || m_axi_wstrb !== wstrb) obs_bus_bad++;
            end
            if (m_axi_arvalid) begin
                obs_ar_hi++;
                if (m_axi_araddr !== addr) obs_bus_bad++;
            end
            m_axi_awready = m_axi_awvalid && (obs_aw_hi > aw_dly);
            if (m_axi_awready) begin obs_aw_hs++; aw_k = k; end
            m_axi_wready = m_axi_wvalid && (obs_w_hi > w_dly);
            if (m_axi_wready) begin obs_w_hs++; w_k = k; end
            m_axi_arready = m_axi_arvalid && (obs_ar_hi > ar_dly);
            if (m_axi_arready) begin obs_ar_hs++; ar_k = k; end
            m_axi_bvalid = !b_done && obs_aw_hs > 0 && obs_w_hs > 0 &&
                           (k > ((aw_k > w_k ? aw_k : w_k) + b_dly));
            m_axi_bresp  = m_axi_bvalid ? s_resp : 2'($urandom);
            if (m_axi_bvalid && m_axi_bready) begin b_done = 1; obs_b_hs++; end
            m_axi_rvalid = !r_done && obs_ar_hs > 0 && (k > ar_k + r_dly);
            m_axi_rdata  = m_axi_rvalid ? s_rdata : $urandom;
            m_axi_rresp  = m_axi_rvalid ? s_resp : 2'($urandom);
            if (m_axi_rvalid && m_axi_rready) begin r_done = 1; obs_r_hs++; end
            if (rsp_timeout === 1'b1) obs_to_seen++;
            if (rsp_valid === 1'b1) begin
                obs_pulses++;
                if (obs_rsp_k < 0) begin
                    obs_rsp_k   = k;
                    obs_rdata   = rsp_rdata;
                    obs_resp    = rsp_resp;
                    obs_timeout = rsp_timeout;
                end
            end
            if (obs_pulses == 0 || rsp_valid === 1'b1) begin
                if (busy !== 1'b1 || cmd_ready !== 1'b0) obs_stat_bad++;
            end else if (obs_ready_k < 0 && cmd_ready === 1'b1) begin
                obs_ready_k = k;
                if (busy !== 1'b0) obs_stat_bad++;
            end
            @(negedge clk_100m);
        end
        slave_idle();
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk_100m);
        @(negedge clk_100m);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [4:0] hs;
        apply_reset();
        hs = {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready};
        n_vec++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL reset cmd_ready: got %b want 1", cmd_ready); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset busy: got %b want 0", busy); end
        n_vec++; if (hs !== 5'b0) begin n_err++; $display("FAIL reset valids/readies: got %b want 00000", hs); end
        n_vec++; if ({rsp_valid, rsp_timeout, rsp_resp} !== 4'b0) begin n_err++; $display("FAIL reset rsp flags: got %b%b%b want 0000", rsp_valid, rsp_timeout, rsp_resp); end
        n_vec++; if (rsp_rdata !== '0) begin n_err++; $display("FAIL reset rsp_rdata: got %h want 0", rsp_rdata); end
        n_vec++; if ({m_axi_awaddr, m_axi_araddr, m_axi_wdata, m_axi_wstrb} !== '0) begin n_err++; $display("FAIL reset addr/data: got %h %h %h %h want 0", m_axi_awaddr, m_axi_araddr, m_axi_wdata, m_axi_wstrb); end
    endtask

    task automatic test_write_zero_wait();
        run_txn(1'b1, 11'h004, 32'h0000_00A5, 4'hF, 0, 0, 0, 0, 0, AXI_OKAY, 32'hDEAD_BEEF, 6);
        n_vec++; if (obs_rsp_k !== 3) begin n_err++; $display("FAIL wr0 latency: got %0d want 3", obs_rsp_k); end
        n_vec++; if (obs_pulses !== 1) begin n_err++; $display("FAIL wr0 pulses: got %0d want 1", obs_pulses); end
        n_vec++; if (obs_resp !== AXI_OKAY) begin n_err++; $display("FAIL wr0 resp: got %0d want 0", obs_resp); end
        n_vec++; if (obs_rdata !== '0) begin n_err++; $display("FAIL wr0 rdata: got %h want 0", obs_rdata); end
        n_vec++; if (obs_aw_hi !== 1 || obs_w_hi !== 1) begin n_err++; $display("FAIL wr0 aw/w cycles: got %0d/%0d want 1/1", obs_aw_hi, obs_w_hi); end
        n_vec++; if (obs_bus_bad !== 0 || obs_stat_bad !== 0) begin n_err++; $display("FAIL wr0 protocol: got %0d/%0d want 0/0", obs_bus_bad, obs_stat_bad); end
        n_vec++; if (obs_ready_k !== 4) begin n_err++; $display("FAIL wr0 cmd_ready return: got %0d want 4", obs_ready_k); end
    endtask

    task automatic test_aw_delay();
        run_txn(1'b1, 11'h004, 32'h0000_005A, 4'h3, 3, 0, 0, 0, 0, AXI_OKAY, '0, 9);
        n_vec++; if (obs_w_hi !== 1) begin n_err++; $display("FAIL awdly wvalid cycles: got %0d want 1", obs_w_hi); end
        n_vec++; if (obs_aw_hi !== 4) begin n_err++; $display("FAIL awdly awvalid cycles: got %0d want 4", obs_aw_hi); end
        n_vec++; if (obs_aw_hs !== 1 || obs_w_hs !== 1 || obs_b_hs !== 1) begin n_err++; $display("FAIL awdly handshakes: got %0d/%0d/%0d want 1/1/1", obs_aw_hs, obs_w_hs, obs_b_hs); end
        n_vec++; if (obs_bus_bad !== 0) begin n_err++; $display("FAIL awdly addr stable: got %0d bad want 0", obs_bus_bad); end
        n_vec++; if (obs_rsp_k !== 6 || obs_pulses !== 1) begin n_err++; $display("FAIL awdly rsp: got k=%0d n=%0d want k=6 n=1", obs_rsp_k, obs_pulses); end
    endtask

    task automatic test_read_wait();
        run_txn(1'b0, 11'h010, '0, 4'h0, 0, 0, 0, 0, 5, AXI_OKAY, 32'h1234_5678, 11);
        n_vec++; if (obs_rdata !== 32'h1234_5678) begin n_err++; $display("FAIL rd5 rdata: got %h want 12345678", obs_rdata); end
        n_vec++; if (obs_pulses !== 1) begin n_err++; $display("FAIL rd5 pulses: got %0d want 1", obs_pulses); end
        n_vec++; if (obs_rsp_k !== 8) begin n_err++; $display("FAIL rd5 latency: got %0d want 8", obs_rsp_k); end
        n_vec++; if (obs_resp !== AXI_OKAY || obs_ar_hi !== 1) begin n_err++; $display("FAIL rd5 resp/arvalid: got %0d/%0d want 0/1", obs_resp, obs_ar_hi); end
        n_vec++; if (obs_bus_bad !== 0 || obs_stat_bad !== 0) begin n_err++; $display("FAIL rd5 protocol: got %0d/%0d want 0/0", obs_bus_bad, obs_stat_bad); end
    endtask

    task automatic test_read_slverr();
        run_txn(1'b0, 11'h024, '0, 4'h0, 0, 0, 0, 2, 1, AXI_SLVERR, 32'hCAFE_0001, 8);
        n_vec++; if (obs_resp !== AXI_SLVERR) begin n_err++; $display("FAIL rderr resp: got %0d want 2", obs_resp); end
        n_vec++; if (obs_timeout !== 1'b0) begin n_err++; $display("FAIL rderr timeout: got %b want 0", obs_timeout); end
        n_vec++; if (obs_rsp_k !== 6 || obs_ready_k !== 7) begin n_err++; $display("FAIL rderr timing: got %0d/%0d want 6/7", obs_rsp_k, obs_ready_k); end
    endtask

    // Random mix; expectations come from the wait-state arithmetic of the handshake rules.
    task automatic test_random_traffic();
        for (int i = 0; i < 24; i++) begin
            logic              wr;
            logic [ADDR_W-1:0] addr;
            logic [DATA_W-1:0] wdata;
            logic [DATA_W-1:0] sdata;
            logic [3:0]        strb;
            logic [1:0]        resp;
            int aw, w, b, ar, r, sel, exp_k;
            logic [DATA_W-1:0] exp_rdata;
            wr    = 1'($urandom);
            addr  = ADDR_W'($urandom);
            wdata = $urandom;
            sdata = $urandom;
            strb  = 4'($urandom);
            aw = $urandom_range(0, 4); w = $urandom_range(0, 4); b = $urandom_range(0, 4);
            ar = $urandom_range(0, 4); r = $urandom_range(0, 4);
            sel  = $urandom_range(0, 2);
            resp = (sel == 0) ? AXI_OKAY : (sel == 1) ? AXI_SLVERR : AXI_DECERR;
            exp_k     = wr ? 3 + ((aw > w) ? aw : w) + b : 3 + ar + r;
            exp_rdata = wr ? '0 : sdata;
            run_txn(wr, addr, wdata, strb, aw, w, b, ar, r, resp, sdata, exp_k + 2);
            n_vec++; if (obs_rsp_k !== exp_k || obs_pulses !== 1) begin n_err++; $display("FAIL rand%0d rsp timing: got k=%0d n=%0d want k=%0d n=1", i, obs_rsp_k, obs_pulses, exp_k); end
            n_vec++; if (obs_rdata !== exp_rdata || obs_resp !== resp || obs_timeout !== 1'b0) begin n_err++; $display("FAIL rand%0d rsp data: got %h/%0d/%b want %h/%0d/0", i, obs_rdata, obs_resp, obs_timeout, exp_rdata, resp); end
            n_vec++; if (obs_aw_hi !== (wr ? aw + 1 : 0) || obs_w_hi !== (wr ? w + 1 : 0) || obs_ar_hi !== (wr ? 0 : ar + 1)) begin n_err++; $display("FAIL rand%0d valid cycles: got %0d/%0d/%0d want %0d/%0d/%0d", i, obs_aw_hi, obs_w_hi, obs_ar_hi, wr ? aw + 1 : 0, wr ? w + 1 : 0, wr ? 0 : ar + 1); end
            n_vec++; if (obs_bus_bad !== 0 || obs_stat_bad !== 0 || obs_ready_k !== exp_k + 1) begin n_err++; $display("FAIL rand%0d protocol: got bad=%0d/%0d ready=%0d want 0/0/%0d", i, obs_bus_bad, obs_stat_bad, obs_ready_k, exp_k + 1); end
        end
    endtask

    task automatic test_timeout();
`ifdef PLL_AXI_TIMEOUT_EN
        run_txn(1'b1, 11'h008, 32'h0000_0011, 4'hF, 0, 0, 100000, 0, 0, AXI_OKAY, '0, 20);
        n_vec++; if (obs_rsp_k !== 17 || obs_pulses !== 1) begin n_err++; $display("FAIL tmo rsp timing: got k=%0d n=%0d want k=17 n=1", obs_rsp_k, obs_pulses); end
        n_vec++; if (obs_timeout !== 1'b1 || obs_resp !== AXI_SLVERR || obs_rdata !== '0) begin n_err++; $display("FAIL tmo rsp: got %b/%0d/%h want 1/2/0", obs_timeout, obs_resp, obs_rdata); end
        n_vec++; if (obs_ready_k !== 18 || m_axi_bready !== 1'b0) begin n_err++; $display("FAIL tmo back to idle: got ready=%0d bready=%b want 18/0", obs_ready_k, m_axi_bready); end
        run_txn(1'b0, 11'h00C, '0, 4'h0, 0, 0, 0, 0, 0, AXI_OKAY, 32'h0000_0777, 5);
        n_vec++; if (obs_timeout !== 1'b0 || obs_rdata !== 32'h0000_0777) begin n_err++; $display("FAIL tmo recovery: got %b/%h want 0/00000777", obs_timeout, obs_rdata); end
`else
        run_txn(1'b1, 11'h008, 32'h0000_0011, 4'hF, 0, 0, 100000, 0, 0, AXI_OKAY, '0, 40);
        n_vec++; if (obs_pulses !== 0 || obs_to_seen !== 0) begin n_err++; $display("FAIL stall no response: got pulses=%0d timeout_cycles=%0d want 0/0", obs_pulses, obs_to_seen); end
        n_vec++; if (obs_stat_bad !== 0 || m_axi_bready !== 1'b1) begin n_err++; $display("FAIL stall still waiting: got bad=%0d bready=%b want 0/1", obs_stat_bad, m_axi_bready); end
        apply_reset();
        n_vec++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL stall reset: got ready=%b busy=%b want 1/0", cmd_ready, busy); end
`endif
    endtask

    task automatic test_reset_mid();
        logic [4:0] hs;
        int         stray;
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 11'h020;
        @(posedge clk_100m);
        @(negedge clk_100m);
        cmd_valid     = 1'b0;
        m_axi_arready = 1'b1;
        @(posedge clk_100m);
        @(negedge clk_100m);
        m_axi_arready = 1'b0;
        @(posedge clk_100m);
        @(negedge clk_100m);
        n_vec++; if (m_axi_rready !== 1'b1) begin n_err++; $display("FAIL rstmid in RD_RESP: got rready=%b want 1", m_axi_rready); end
        reset = 1'b1;
        @(posedge clk_100m);
        @(negedge clk_100m);
        reset = 1'b0;
        hs = {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready};
        n_vec++; if (hs !== 5'b0) begin n_err++; $display("FAIL rstmid valids/readies: got %b want 00000", hs); end
        n_vec++; if (cmd_ready !== 1'b1 || busy !== 1'b0 || rsp_valid !== 1'b0) begin n_err++; $display("FAIL rstmid status: got ready=%b busy=%b rsp=%b want 1/0/0", cmd_ready, busy, rsp_valid); end
        stray = 0;
        repeat (4) begin
            @(negedge clk_100m);
            if (rsp_valid !== 1'b0) stray++;
        end
        n_vec++; if (stray !== 0) begin n_err++; $display("FAIL rstmid stray response: got %0d pulses want 0", stray); end
    endtask

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        cmd_wstrb = '0;
        slave_idle();
        @(negedge clk_100m);
        test_reset();
        test_write_zero_wait();
        test_aw_delay();
        test_read_wait();
        test_read_slverr();
        test_random_traffic();
        test_timeout();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish after 500000 ns want finish");
        $fatal(1);
    end

endmodule
